// File: rtl/enum_seq_ctrl.sv
// rtl/enum_seq_ctrl.sv - request/sweep sequencer for four enum-typed output fields
// Optional atomic shadow update enabled by `ENUM_SEQ_SHADOW_EN.
module enum_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_sel,
    input  logic       req_code,
    input  logic       sweep_start,
    input  logic       commit,
    output logic [4:0] var1,
    output logic [5:0] var2,
    output logic [6:0] var3,
    output logic [7:0] var4,
    output logic       done
);

    localparam logic [4:0] V1_A = 5'h07;
    localparam logic [4:0] V1_B = 5'h1C;
    localparam logic [5:0] V2_A = 6'h07;
    localparam logic [5:0] V2_B = 6'h38;
    localparam logic [6:0] V3_A = 7'h1C;
    localparam logic [6:0] V3_B = 7'h63;
    localparam logic [7:0] V4_A = 8'h5A;
    localparam logic [7:0] V4_B = 8'hD3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [1:0] sel_q, sel_d;
    logic       code_q, code_d;

    // Working fields: drive the outputs directly, or act as shadows when enabled.
    logic [4:0] f1_q, f1_d;
    logic [5:0] f2_q, f2_d;
    logic [6:0] f3_q, f3_d;
    logic [7:0] f4_q, f4_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            sel_q   <= 2'd0;
            code_q  <= 1'b0;
            f1_q    <= V1_A;
            f2_q    <= V2_A;
            f3_q    <= V3_A;
            f4_q    <= V4_A;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            code_q  <= code_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            f3_q    <= f3_d;
            f4_q    <= f4_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        code_d  = code_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        f3_d    = f3_q;
        f4_d    = f4_q;
        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d = SWEEP;
                    idx_d   = 2'd0;
                end else if (req_valid) begin
                    sel_d   = req_sel;
                    code_d  = req_code;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                case (sel_q)
                    2'd0:    f1_d = code_q ? V1_B : V1_A;
                    2'd1:    f2_d = code_q ? V2_B : V2_A;
                    2'd2:    f3_d = code_q ? V3_B : V3_A;
                    default: f4_d = code_q ? V4_B : V4_A;
                endcase
                state_d = DONE;
            end
            SWEEP: begin
                // Toggle to the other literal; any illegal value would fall back to the first.
                case (idx_q)
                    2'd0:    f1_d = (f1_q == V1_A) ? V1_B : V1_A;
                    2'd1:    f2_d = (f2_q == V2_A) ? V2_B : V2_A;
                    2'd2:    f3_d = (f3_q == V3_A) ? V3_B : V3_A;
                    default: f4_d = (f4_q == V4_A) ? V4_B : V4_A;
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);

`ifdef ENUM_SEQ_SHADOW_EN
    logic [4:0] o1_q, o1_d;
    logic [5:0] o2_q, o2_d;
    logic [6:0] o3_q, o3_d;
    logic [7:0] o4_q, o4_d;
    logic       pend_q, pend_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            o1_q   <= V1_A;
            o2_q   <= V2_A;
            o3_q   <= V3_A;
            o4_q   <= V4_A;
            pend_q <= 1'b0;
        end else begin
            o1_q   <= o1_d;
            o2_q   <= o2_d;
            o3_q   <= o3_d;
            o4_q   <= o4_d;
            pend_q <= pend_d;
        end
    end

    // Copies always take the registered shadows, so a same-edge request is not included.
    always_comb begin
        o1_d   = o1_q;
        o2_d   = o2_q;
        o3_d   = o3_q;
        o4_d   = o4_q;
        pend_d = pend_q;
        if ((state_q == IDLE && commit) || (state_q == DONE && (pend_q || commit))) begin
            o1_d   = f1_q;
            o2_d   = f2_q;
            o3_d   = f3_q;
            o4_d   = f4_q;
            pend_d = 1'b0;
        end else if (commit) begin
            pend_d = 1'b1;
        end
    end

    assign var1 = o1_q;
    assign var2 = o2_q;
    assign var3 = o3_q;
    assign var4 = o4_q;
`else
    logic unused_commit;
    assign unused_commit = commit;

    assign var1 = f1_q;
    assign var2 = f2_q;
    assign var3 = f3_q;
    assign var4 = f4_q;
`endif

endmodule

// File: tb/tb_enum_seq_ctrl.sv
// tb/tb_enum_seq_ctrl.sv - scoreboard bench for enum_seq_ctrl with a field-code reference model
module tb_enum_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_sel;
    logic       req_code;
    logic       sweep_start;
    logic       commit;
    logic [4:0] var1;
    logic [5:0] var2;
    logic [6:0] var3;
    logic [7:0] var4;
    logic       done;

    int checks   = 0;
    int failures = 0;

    // Model: each field holds a literal choice (0 = first, 1 = second).
    bit          sh_code [4];
    bit          out_code[4];
    logic [31:0] exp_q[$];

    enum_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_code   (req_code),
        .sweep_start(sweep_start),
        .commit     (commit),
        .var1       (var1),
        .var2       (var2),
        .var3       (var3),
        .var4       (var4),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lit(int k, bit c);
        case (k)
            0:       return c ? 8'h1C : 8'h07;
            1:       return c ? 8'h38 : 8'h07;
            2:       return c ? 8'h63 : 8'h1C;
            default: return c ? 8'hD3 : 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] exp_snap();
        return {lit(0, out_code[0]), lit(1, out_code[1]), lit(2, out_code[2]), lit(3, out_code[3])};
    endfunction

    function automatic logic [31:0] act_snap();
        return {3'b0, var1, 2'b0, var2, 1'b0, var3, var4};
    endfunction

    function automatic logic [7:0] act_field(int k);
        case (k)
            0:       return {3'b0, var1};
            1:       return {2'b0, var2};
            2:       return {1'b0, var3};
            default: return var4;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(int k, bit c);
        sh_code[k] = c;
`ifndef ENUM_SEQ_SHADOW_EN
        out_code[k] = c;
`endif
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            sh_code[k]  = 1'b0;
            out_code[k] = 1'b0;
        end
        exp_q.delete();
    endtask

    // Monitor: every done pulse must match the oldest expected snapshot.
    always @(posedge clk) begin
        #1;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("done_snapshot", act_snap(), exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 10) begin
            tick();
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(logic [1:0] sel, bit code);
        wait_ready();
        req_valid = 1'b1;
        req_sel   = sel;
        req_code  = code;
        model_write(int'(sel), code);
        exp_q.push_back(exp_snap());
        tick();
        req_valid = 1'b0;
        chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
        tick();
        chk("req_field", {24'b0, act_field(int'(sel))}, {24'b0, lit(int'(sel), out_code[sel])});
        chk("req_done", {31'b0, done}, 32'd1);
        tick();
    endtask

    task automatic do_sweep();
        wait_ready();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            model_write(k, ~sh_code[k]);
            if (k == 3) exp_q.push_back(exp_snap());
            chk("sweep_no_done", {31'b0, done}, 32'd0);
            tick();
            chk("sweep_field", {24'b0, act_field(k)}, {24'b0, lit(k, out_code[k])});
        end
        chk("sweep_done", {31'b0, done}, 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_sel = 2'd0; req_code = 1'b0;
        sweep_start = 1'b0; commit = 1'b0;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("reset_vars", act_snap(), exp_snap());
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_done", {31'b0, done}, 32'd0);

        do_req(2'd3, 1'b1);
        chk("req3_others", act_snap(), exp_snap());

        do_sweep();
        chk("sweep1_vars", act_snap(), exp_snap());
        do_sweep();
        chk("sweep2_vars", act_snap(), exp_snap());

        // Sweep wins over a concurrent request; the held request goes in afterwards.
        req_valid = 1'b1; req_sel = 2'd1; req_code = ~sh_code[1];
        do_sweep();
        do_req(2'd1, req_code);
        chk("collide_vars", act_snap(), exp_snap());

        // Reset in the middle of a sweep.
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        model_reset();
        chk("midreset_vars", act_snap(), exp_snap());
        chk("midreset_ready", {31'b0, req_ready}, 32'd1);
        chk("midreset_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        tick();
        chk("midreset_idle", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) do_sweep();
            else do_req(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
            chk("rand_vars", act_snap(), exp_snap());
        end

`ifdef ENUM_SEQ_SHADOW_EN
        // Two requests stay in the shadows; a commit during the second APPLY lands after DONE.
        do_req(2'd0, ~sh_code[0]);
        chk("shadow_hold", act_snap(), exp_snap());
        wait_ready();
        req_valid = 1'b1; req_sel = 2'd2; req_code = ~sh_code[2];
        model_write(2, req_code);
        exp_q.push_back(exp_snap());
        tick();
        req_valid = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        chk("shadow_in_done", act_snap(), exp_snap());
        tick();
        for (int k = 0; k < 4; k++) out_code[k] = sh_code[k];
        chk("shadow_commit", act_snap(), exp_snap());
`endif

        tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
